// File: rtl/dec_pkg.sv
// Shared types for the parameterised one-hot decoder with self-checking.
// Holds the fault FSM state encoding and the one-hot expected-value helper.
package dec_pkg;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_N     = 2 ** MAX_SEL_W;

  typedef enum logic {
    ST_OK    = 1'b0,
    ST_FAULT = 1'b1
  } dec_state_e;

  // Widest possible one-hot; callers keep the low 2**SEL_W bits.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_onehot_chk.sv
// Combinational one-hot checker: flags a decode word that disagrees with
// the registered select/enable it was produced from.
module dec_onehot_chk
  import dec_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [2**SEL_W-1:0] dec,
  input  logic [SEL_W-1:0]    sel_q,
  input  logic                en_q,
  input  logic                vld,
  output logic                violation
);

  localparam int N = 2 ** SEL_W;

  logic [MAX_N-1:0] oh_full;
  logic [N-1:0]     expected;

  always_comb begin
    oh_full   = onehot(MAX_SEL_W'(sel_q));
    expected  = en_q ? oh_full[N-1:0] : '0;
    violation = vld && (dec != expected);
  end

endmodule

// File: rtl/dec_param_chk.sv
// Registered one-hot decoder with pipelined self-check, sticky fault FSM,
// saturating fault counter and first-error select capture.
// Optional fault injection on the decode output: `define DEC_FAULT_INJ_EN.
module dec_param_chk
  import dec_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  input  logic                clr_fault,
`ifdef DEC_FAULT_INJ_EN
  input  logic                fi_en,
  input  logic [SEL_W-1:0]    fi_bit,
  input  logic                fi_val,
`endif
  output logic [2**SEL_W-1:0] dec,
  output logic                out_vld,
  output logic                fault,
  output logic                err_pulse,
  output logic [CNT_W-1:0]    fault_cnt,
  output logic [SEL_W-1:0]    err_sel
);

  localparam int N = 2 ** SEL_W;

  logic [N-1:0]     dec_q;
  logic [N-1:0]     dec_chk;
  logic             out_vld_q;
  logic [SEL_W-1:0] sel_q;
  logic             en_q;
  logic             violation;
  logic             err_pulse_q;
  logic [SEL_W-1:0] err_sel_pend;
  dec_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] err_sel_q, err_sel_d;

  // Decode stage; sel/en are kept alongside dec for the checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= '0;
      out_vld_q <= 1'b0;
      sel_q     <= '0;
      en_q      <= 1'b0;
    end else begin
      out_vld_q <= in_vld;
      if (in_vld) begin
        dec_q <= en ? N'(1) << sel : '0;
        sel_q <= sel;
        en_q  <= en;
      end
    end
  end

  // Forcing sits after the register so the checker sees exactly what leaves the block.
`ifdef DEC_FAULT_INJ_EN
  always_comb begin
    dec_chk = dec_q;
    if (fi_en) dec_chk[fi_bit] = fi_val;
  end
`else
  assign dec_chk = dec_q;
`endif

  dec_onehot_chk #(
    .SEL_W (SEL_W)
  ) u_chk (
    .dec       (dec_chk),
    .sel_q     (sel_q),
    .en_q      (en_q),
    .vld       (out_vld_q),
    .violation (violation)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q  <= 1'b0;
      err_sel_pend <= '0;
    end else begin
      err_pulse_q  <= violation;
      err_sel_pend <= sel_q;
    end
  end

  // A new error always beats a same-cycle clear.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_sel_d = err_sel_q;
    if (err_pulse_q) begin
      state_d = ST_FAULT;
      if (clr_fault)          cnt_d = CNT_W'(1);
      else if (cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
      if (clr_fault || state_q == ST_OK) err_sel_d = err_sel_pend;
    end else if (clr_fault) begin
      state_d   = ST_OK;
      cnt_d     = '0;
      err_sel_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OK;
      cnt_q     <= '0;
      err_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_sel_q <= err_sel_d;
    end
  end

  assign dec       = dec_chk;
  assign out_vld   = out_vld_q;
  assign err_pulse = err_pulse_q;
  assign fault     = (state_q == ST_FAULT);
  assign fault_cnt = cnt_q;
  assign err_sel   = err_sel_q;

endmodule

// File: doc/dec_param_chk.md
DEC_PARAM_CHK -- requirements
Module: dec_param_chk

Interface
REQ-001 Parameter: SEL_W, 4, select width; output width is 2**SEL_W (SEL_W range 2..6).
REQ-002 Parameter: CNT_W, 8, fault counter width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_vld  input  1  sample sel/en this cycle.
REQ-006 Port: en  input  1  decoder enable; 0 gives all-zero output.
REQ-007 Port: sel  input  SEL_W  binary select.
REQ-008 Port: clr_fault  input  1  clears sticky fault state, counter and err_sel.
REQ-009 Port: dec  output  2**SEL_W  registered one-hot decode.
REQ-010 Port: out_vld  output  1  dec updated this cycle.
REQ-011 Port: fault  output  1  sticky fault flag (high in state FAULT).
REQ-012 Port: err_pulse  output  1  one-cycle pulse per detected violation.
REQ-013 Port: fault_cnt  output  CNT_W  saturating violation count.
REQ-014 Port: err_sel  output  SEL_W  sel value of first violation since last clear.

Function
REQ-015 in_vld=1 at edge t: dec at t+1 = en ? (1 << sel) : 0; out_vld=1 at t+1; latency exactly 1 cycle.
REQ-016 in_vld=0: dec holds previous value; out_vld=0 next cycle.
REQ-017 Checker samples dec plus registered sel/en each out_vld cycle; violation = (en_q and dec != 1<<sel_q) or (!en_q and dec != 0).
REQ-018 Violation detected at t+1 asserts err_pulse at t+2 for one cycle; checker is pipelined, back-to-back in_vld supported every cycle.
REQ-019 FSM states OK and FAULT: OK->FAULT on err_pulse; FAULT->OK on clr_fault with no same-cycle err_pulse; otherwise hold.
REQ-020 fault_cnt increments per err_pulse, saturates at 2**CNT_W-1, never wraps.
REQ-021 err_sel captured only on OK->FAULT transition; later violations do not overwrite it.
REQ-022 clr_fault and err_pulse same cycle: error wins; state FAULT, fault_cnt=1, err_sel=sel of new violation.
REQ-023 clr_fault in OK: fault_cnt and err_sel cleared to 0, no other effect.
REQ-024 clr_fault does not affect dec, out_vld or in-flight decode.

Reset
REQ-025 rst_n low: dec=0, out_vld=0, err_pulse=0, fault=0, fault_cnt=0, err_sel=0, FSM=OK, checker pipeline flushed, immediately and asynchronously.
REQ-026 Reset deassertion mid-stream: first valid output only after a new in_vld; no err_pulse from pre-reset data.

Configuration
REQ-027 Macro DEC_FAULT_INJ_EN defined: extra inputs fi_en (1), fi_bit (SEL_W), fi_val (1); while fi_en=1, dec bit fi_bit is forced to fi_val on the output and at checker input.
REQ-028 DEC_FAULT_INJ_EN undefined: ports absent, no forcing logic; checker retained; error-free operation gives err_pulse never high.

Structure
REQ-029 Shared package dec_pkg holds FSM state enum (OK, FAULT) and one-hot expected-value function.
REQ-030 Checker is sub-module dec_onehot_chk (inputs dec, sel_q, en_q, vld; output violation); top holds decode register, FSM, counter, injection.

Verification (SEL_W=4, CNT_W=8)
REQ-031 Sweep sel 0..15, en=1, in_vld every cycle -> dec=0x0001..0x8000 one cycle later, err_pulse never high.
REQ-032 en=0, sel=5 -> dec=0x0000, no fault; in_vld=0 following cycle -> dec held, out_vld=0.
REQ-033 Macro on: fi_en=1, fi_bit=3, fi_val=0, sel=3 -> dec=0x0000, err_pulse at t+2, fault=1, fault_cnt=1, err_sel=3.
REQ-034 Macro on: stuck-at-1 bit 0 held, 300 samples sel=2 -> fault_cnt saturates at 255; err_sel stays 2.
REQ-035 clr_fault same cycle as err_pulse -> fault=1, fault_cnt=1; clr_fault alone next -> fault=0, fault_cnt=0.
REQ-036 rst_n low mid-stream with fault=1 -> all outputs 0 asynchronously; no err_pulse after release until new violation.
